// File: rtl/mem_arbiter_n.sv
// N-port memory arbiter: latches single-cycle requests per port and serialises them
// onto one memory bus with a single outstanding transaction, fixed-priority or round-robin.

module mem_arbiter_slot #(
  parameter int RW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic          conflict,
  input  logic          set_pend,
  input  logic          clr_pend,
  input  logic [RW-1:0] d,
  output logic          pending,
  output logic          overflow,
  output logic [RW-1:0] q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pending  <= 1'b0;
      overflow <= 1'b0;
      q        <= '0;
    end else begin
      if (req_valid && !conflict) q <= d;
      if (set_pend) pending <= 1'b1;
      else if (clr_pend) pending <= 1'b0;
      if (req_valid && conflict) overflow <= 1'b1;
    end
endmodule

module mem_arbiter_n #(
  parameter int NPORT = 2,
  parameter int RR    = 1,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                    rst,
  input  logic                    clk,
  input  logic [NPORT-1:0]        req_valid,
  input  logic [NPORT-1:0]        req_instr,
  input  logic [NPORT*AW-1:0]     req_addr,
  input  logic [NPORT*DW-1:0]     req_wdata,
  input  logic [NPORT*DW/8-1:0]   req_wstrb,
  output logic [DW-1:0]           resp_rdata,
  output logic [NPORT-1:0]        resp_ready,
  output logic [NPORT-1:0]        overflow,
  output logic                    busy,
  output logic                    memory_valid,
  output logic                    memory_instr,
  output logic [AW-1:0]           memory_addr,
  output logic [DW-1:0]           memory_wdata,
  output logic [DW/8-1:0]         memory_wstrb,
  input  logic [DW-1:0]           memory_rdata,
  input  logic                    memory_ready
);
  localparam int SW = DW / 8;
  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef struct packed {
    logic          instr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
  } mreq_t;
  localparam int RW = $bits(mreq_t);

  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;

  logic [PW-1:0]    gnt, ptr, scan_ptr, win;
  logic [NPORT-1:0] pending, conflict, accept, cand, set_pend, clr_pend, win_oh;
  mreq_t [NPORT-1:0] in_req, slot_req;
  mreq_t            win_req;
  logic             done, issue;

  for (genvar i = 0; i < NPORT; i++) begin : g_port
    assign in_req[i] = '{instr: req_instr[i],
                         addr:  req_addr[i*AW +: AW],
                         wdata: req_wdata[i*DW +: DW],
                         wstrb: req_wstrb[i*SW +: SW]};
    // The in-flight port may re-request in the very cycle it completes.
    assign conflict[i] = pending[i] ||
                         (state == BUSY && gnt == PW'(i) && !memory_ready);
    mem_arbiter_slot #(.RW(RW)) u_slot (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid[i]),
      .conflict (conflict[i]),
      .set_pend (set_pend[i]),
      .clr_pend (clr_pend[i]),
      .d        (in_req[i]),
      .pending  (pending[i]),
      .overflow (overflow[i]),
      .q        (slot_req[i])
    );
  end

  assign accept = req_valid & ~conflict;
  assign busy   = (state == BUSY);

  always_comb begin
    int idx;
    idx      = 0;
    done     = (state == BUSY) && memory_ready;
    cand     = pending | accept;
    issue    = ((state == IDLE) || done) && (|cand);
    // On completion the pointer moves to the finishing port before the next pick.
    scan_ptr = (RR != 0 && done) ? gnt : ptr;
    win      = '0;
    if (RR == 0) begin
      for (int k = NPORT - 1; k >= 0; k--)
        if (cand[k]) win = PW'(k);
    end else begin
      for (int k = NPORT; k >= 1; k--) begin
        idx = (int'(scan_ptr) + k) % NPORT;
        if (cand[idx]) win = PW'(idx);
      end
    end
    win_req    = pending[win] ? slot_req[win] : in_req[win];
    win_oh     = issue ? (NPORT'(1) << win) : '0;
    clr_pend   = win_oh & pending;
    set_pend   = accept & ~win_oh;
    resp_ready = done ? (NPORT'(1) << gnt) : '0;
    resp_rdata = done ? memory_rdata : '0;
    state_nx   = state;
    if (issue) state_nx = BUSY;
    else if (done) state_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      gnt          <= '0;
      ptr          <= PW'(NPORT - 1);
      memory_valid <= 1'b0;
      memory_instr <= 1'b0;
      memory_addr  <= '0;
      memory_wdata <= '0;
      memory_wstrb <= '0;
    end else begin
      state <= state_nx;
      if (done && RR != 0) ptr <= gnt;
      if (issue) begin
        gnt          <= win;
        memory_valid <= 1'b1;
        memory_instr <= win_req.instr;
        memory_addr  <= win_req.addr;
        memory_wdata <= win_req.wdata;
        memory_wstrb <= win_req.wstrb;
      end else if (done) begin
        memory_valid <= 1'b0;
      end
    end
endmodule
